// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: registered request fields
// from the stage, ready/rdata returned by the memory.
interface mem_access_stage_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            ready;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: load/store over dmem req/ready port, branch/jump
// redirect, MEM/WB register. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Ctl_MemtoReg_in,
  input  logic            Ctl_RegWrite_in,
  input  logic            Ctl_MemRead_in,
  input  logic            Ctl_MemWrite_in,
  input  logic            Ctl_branch_in,
  input  logic            Zero_in,
  input  logic            jal_in,
  input  logic            jalr_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      Rd_in,
  input  logic [XLEN-1:0] ALUresult_in,
  input  logic [XLEN-1:0] PCimm_in,
  input  logic [XLEN-1:0] ReadData2_in,
  input  logic [XLEN-1:0] PC_in,
  mem_access_stage_if.master dmem,
  output logic            stall_out,
  output logic            PCSrc_out,
  output logic [XLEN-1:0] PCtarget_out,
  output logic            flush_out,
  output logic [XLEN-1:0] mem_fwd_data_out,
  output logic            Ctl_MemtoReg_out,
  output logic            Ctl_RegWrite_out,
  output logic [4:0]      Rd_out,
  output logic [XLEN-1:0] ReadData_out,
  output logic [XLEN-1:0] ALUresult_out,
  output logic [XLEN-1:0] PC_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_out
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_rdata;
  logic            w_access;
  logic            w_go;
  logic            w_bubble;
  logic            w_lb;
  logic            w_lbu;
  logic            w_byte;
  logic            w_taken;
  logic [7:0]      w_lbyte;
  logic [XLEN-1:0] w_ldata;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;

  assign w_access = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign w_lb     = funct3_in == 3'b000;
  assign w_lbu    = funct3_in == 3'b100;
  // unsupported sizes fall back to word access
  assign w_byte   = Ctl_MemWrite_in ? w_lb : (w_lb | w_lbu);

`ifdef MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis = (r_state == IDLE) & w_access & ~w_byte
               & (ALUresult_in[1:0] != 2'b00);
  assign misalign_out = w_mis;
  assign w_go     = w_access & ~w_mis;
  assign w_bubble = stall_out | w_mis;
`else
  assign w_go     = w_access;
  assign w_bubble = stall_out;
`endif

  assign stall_out = ((r_state == IDLE) & w_go)
                   | (r_state == REQ);

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = ReadData2_in;
    if (w_byte) begin
      w_wstrb = 4'b0001 << ALUresult_in[1:0];
      w_wdata = {(XLEN/8){ReadData2_in[7:0]}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rdata    <= '0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.wstrb <= 4'b0000;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_go) begin
          dmem.req   <= 1'b1;
          dmem.we    <= Ctl_MemWrite_in;
          dmem.addr  <= {ALUresult_in[XLEN-1:2], 2'b00};
          dmem.wdata <= w_wdata;
          dmem.wstrb <= Ctl_MemWrite_in ? w_wstrb : 4'b0000;
          r_state    <= REQ;
        end
        REQ: if (dmem.ready) begin
          r_rdata    <= dmem.rdata;
          dmem.req   <= 1'b0;
          dmem.we    <= 1'b0;
          dmem.wstrb <= 4'b0000;
          r_state    <= DONE;
        end
        // EX/MEM advances on this edge, so no reissue
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_lbyte = r_rdata[{ALUresult_in[1:0], 3'b000} +: 8];

  always_comb begin
    w_ldata = r_rdata;
    unique case (1'b1)
      w_lb:    w_ldata = {{(XLEN-8){w_lbyte[7]}}, w_lbyte};
      w_lbu:   w_ldata = {{(XLEN-8){1'b0}}, w_lbyte};
      default: w_ldata = r_rdata;
    endcase
  end

  assign w_taken = Ctl_branch_in &
    ((funct3_in[2:1] == 2'b00) ?
      (funct3_in[0] ? ~Zero_in : Zero_in) : ~Zero_in);

  // redirect waits for DONE when it shares an access
  assign PCSrc_out = ~stall_out &
                     (w_taken | jal_in | jalr_in);
  assign flush_out = PCSrc_out;
  assign PCtarget_out = jalr_in ?
    {ALUresult_in[XLEN-1:1], 1'b0} : PCimm_in;
  assign mem_fwd_data_out = ALUresult_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Rd_out           <= '0;
      ReadData_out     <= '0;
      ALUresult_out    <= '0;
      PC_out           <= '0;
    end else begin
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in & ~w_bubble;
      Ctl_RegWrite_out <= Ctl_RegWrite_in & ~w_bubble;
      Rd_out           <= Rd_in;
      ReadData_out     <= w_ldata;
      ALUresult_out    <= ALUresult_in;
      PC_out           <= PC_in + XLEN'(PC_STEP);
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for
// redirect/pass-through, sequences for memory accesses.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemtoReg, RegWrite, MemRead, MemWrite;
  logic        branch, Zero, jal, jalr;
  logic [2:0]  f3;
  logic [4:0]  Rd;
  logic [31:0] alu, pcimm, rd2, pc;
  logic        stall_out, PCSrc_out, flush_out;
  logic [31:0] PCtarget_out, fwd;
  logic        MemtoReg_out, RegWrite_out;
  logic [4:0]  Rd_out;
  logic [31:0] ReadData_out, ALUresult_out, PC_out;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_out;
`endif

  mem_access_stage_if #(.XLEN(32)) dmem ();

  mem_access_stage dut (
    .clk              (clk),
    .reset            (reset),
    .Ctl_MemtoReg_in  (MemtoReg),
    .Ctl_RegWrite_in  (RegWrite),
    .Ctl_MemRead_in   (MemRead),
    .Ctl_MemWrite_in  (MemWrite),
    .Ctl_branch_in    (branch),
    .Zero_in          (Zero),
    .jal_in           (jal),
    .jalr_in          (jalr),
    .funct3_in        (f3),
    .Rd_in            (Rd),
    .ALUresult_in     (alu),
    .PCimm_in         (pcimm),
    .ReadData2_in     (rd2),
    .PC_in            (pc),
    .dmem             (dmem),
    .stall_out        (stall_out),
    .PCSrc_out        (PCSrc_out),
    .PCtarget_out     (PCtarget_out),
    .flush_out        (flush_out),
    .mem_fwd_data_out (fwd),
    .Ctl_MemtoReg_out (MemtoReg_out),
    .Ctl_RegWrite_out (RegWrite_out),
    .Rd_out           (Rd_out),
    .ReadData_out     (ReadData_out),
    .ALUresult_out    (ALUresult_out),
    .PC_out           (PC_out)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_out     (misalign_out)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  int          nstall;
  logic        cap_seen, cap_we, cap_pcsrc_first;
  logic        cap_rw_mid, done_pcsrc;
  logic [31:0] cap_addr, cap_wdata, done_tgt;
  logic [3:0]  cap_wstrb;

  typedef struct {
    logic        br;
    logic        z;
    logic        jl;
    logic        jr;
    logic [2:0]  f;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] imm;
    logic [31:0] p;
    logic        e_src;
    logic [31:0] e_tgt;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic nop();
    MemtoReg = 0; RegWrite = 0;
    MemRead  = 0; MemWrite = 0;
    branch = 0; Zero = 0; jal = 0; jalr = 0;
    f3 = 3'b000; Rd = '0;
    alu = '0; pcimm = '0; rd2 = '0; pc = '0;
  endtask

  // call at posedge+1 with the access already applied
  task automatic do_access(input int nwait,
                           input logic [31:0] rdv);
    int w;
    logic to;
    w = 0; nstall = 0; cap_seen = 0; to = 1;
    cap_rw_mid = 1'bx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) cap_pcsrc_first = PCSrc_out;
      if (c == 1) cap_rw_mid = RegWrite_out;
      if (!stall_out) begin
        to = 0;
        done_pcsrc = PCSrc_out;
        done_tgt   = PCtarget_out;
        break;
      end
      nstall++;
      if (dmem.req && !cap_seen) begin
        cap_seen  = 1;
        cap_addr  = dmem.addr;
        cap_we    = dmem.we;
        cap_wdata = dmem.wdata;
        cap_wstrb = dmem.wstrb;
      end
      if (dmem.req) begin
        if (w == nwait) begin
          dmem.ready = 1;
          dmem.rdata = rdv;
        end
        w++;
      end
      @(posedge clk); #1;
      dmem.ready = 0;
      dmem.rdata = '0;
    end
    if (to) begin
      total++;
      $display("FAIL access_timeout: got stall %0d expected done",
               nstall);
    end
    @(posedge clk); #1;
    nop();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1,1,0,0,3'b000,0,5'd0,32'h0,
              32'h40,32'h30,1,32'h40,32'h34};
    vt[1] = '{1,0,0,0,3'b000,0,5'd0,32'h0,
              32'h40,32'h30,0,32'h40,32'h34};
    vt[2] = '{1,0,0,0,3'b001,0,5'd0,32'h0,
              32'h88,32'h50,1,32'h88,32'h54};
    vt[3] = '{1,1,0,0,3'b001,0,5'd0,32'h0,
              32'h88,32'h50,0,32'h88,32'h54};
    vt[4] = '{1,0,0,0,3'b100,0,5'd0,32'h1,
              32'h120,32'h60,1,32'h120,32'h64};
    vt[5] = '{1,1,0,0,3'b101,0,5'd0,32'h0,
              32'h120,32'h60,0,32'h120,32'h64};
    vt[6] = '{0,0,0,1,3'b000,1,5'd1,32'h81,
              32'h999,32'h200,1,32'h80,32'h204};
    vt[7] = '{0,0,1,0,3'b000,1,5'd1,32'h0,
              32'h1000,32'h10,1,32'h1000,32'h14};
    vt[8] = '{0,1,0,0,3'b000,1,5'd7,32'h1234,
              32'h40,32'h70,0,32'h40,32'h74};

    nop();
    dmem.ready = 0;
    dmem.rdata = '0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, dmem.req}, 32'h0);
    chk("rst_we",    {31'b0, dmem.we}, 32'h0);
    chk("rst_wstrb", {28'b0, dmem.wstrb}, 32'h0);
    chk("rst_rw",    {31'b0, RegWrite_out}, 32'h0);
    chk("rst_pc",    PC_out, 32'h0);
    chk("rst_rdata", ReadData_out, 32'h0);
    reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      branch = vt[i].br; Zero = vt[i].z;
      jal = vt[i].jl; jalr = vt[i].jr;
      f3 = vt[i].f; RegWrite = vt[i].rw;
      Rd = vt[i].rd; alu = vt[i].a;
      pcimm = vt[i].imm; pc = vt[i].p;
      @(negedge clk);
      chk($sformatf("v%0d_pcsrc", i),
          {31'b0, PCSrc_out}, {31'b0, vt[i].e_src});
      chk($sformatf("v%0d_flush", i),
          {31'b0, flush_out}, {31'b0, vt[i].e_src});
      chk($sformatf("v%0d_stall", i),
          {31'b0, stall_out}, 32'h0);
      if (vt[i].e_src)
        chk($sformatf("v%0d_tgt", i),
            PCtarget_out, vt[i].e_tgt);
      chk($sformatf("v%0d_fwd", i), fwd, vt[i].a);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pcout", i), PC_out, vt[i].e_pc);
      chk($sformatf("v%0d_rw", i),
          {31'b0, RegWrite_out}, {31'b0, vt[i].rw});
      chk($sformatf("v%0d_rd", i),
          {27'b0, Rd_out}, {27'b0, vt[i].rd});
      chk($sformatf("v%0d_alu", i), ALUresult_out, vt[i].a);
    end
    nop();
    @(posedge clk); #1;

    // lw 0x100, ready on first REQ cycle
    MemRead = 1; MemtoReg = 1; RegWrite = 1;
    f3 = 3'b010; alu = 32'h100; Rd = 5'd10; pc = 32'h80;
    do_access(0, 32'hDEADBEEF);
    chk("lw_stall", nstall, 2);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_we", {31'b0, cap_we}, 32'h0);
    chk("lw_bubble", {31'b0, cap_rw_mid}, 32'h0);
    chk("lw_data", ReadData_out, 32'hDEADBEEF);
    chk("lw_rd", {27'b0, Rd_out}, 32'd10);
    chk("lw_rw", {31'b0, RegWrite_out}, 32'h1);
    chk("lw_m2r", {31'b0, MemtoReg_out}, 32'h1);
    chk("lw_pc", PC_out, 32'h84);

    // lb 0x103 with three wait cycles
    MemRead = 1; MemtoReg = 1; RegWrite = 1;
    f3 = 3'b000; alu = 32'h103; Rd = 5'd3;
    do_access(3, 32'h80FFFF12);
    chk("lb_stall", nstall, 5);
    chk("lb_data", ReadData_out, 32'hFFFFFF80);

    MemRead = 1; MemtoReg = 1; RegWrite = 1;
    f3 = 3'b100; alu = 32'h103; Rd = 5'd4;
    do_access(3, 32'h80FFFF12);
    chk("lbu_stall", nstall, 5);
    chk("lbu_data", ReadData_out, 32'h00000080);

    // sb 0x102
    MemWrite = 1; f3 = 3'b000;
    alu = 32'h102; rd2 = 32'h000000AB;
    do_access(0, 32'h0);
    chk("sb_stall", nstall, 2);
    chk("sb_wstrb", {28'b0, cap_wstrb}, 32'h4);
    chk("sb_wdata", cap_wdata, 32'hABABABAB);
    chk("sb_we", {31'b0, cap_we}, 32'h1);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_rw", {31'b0, RegWrite_out}, 32'h0);

    // sw 0x104 with one wait cycle
    MemWrite = 1; f3 = 3'b010;
    alu = 32'h104; rd2 = 32'h12345678;
    do_access(1, 32'h0);
    chk("sw_stall", nstall, 3);
    chk("sw_wstrb", {28'b0, cap_wstrb}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h12345678);

    // access together with jal: redirect only in DONE
    MemRead = 1; RegWrite = 1; f3 = 3'b010;
    alu = 32'h200; jal = 1; pcimm = 32'h500;
    do_access(0, 32'h11111111);
    chk("acc_jal_first", {31'b0, cap_pcsrc_first}, 32'h0);
    chk("acc_jal_done", {31'b0, done_pcsrc}, 32'h1);
    chk("acc_jal_tgt", done_tgt, 32'h500);

`ifdef MISALIGN_TRAP_EN
    MemRead = 1; MemtoReg = 1; RegWrite = 1;
    f3 = 3'b010; alu = 32'h102; Rd = 5'd9;
    @(negedge clk);
    chk("mis_stall", {31'b0, stall_out}, 32'h0);
    chk("mis_flag", {31'b0, misalign_out}, 32'h1);
    @(posedge clk); #1;
    nop();
    chk("mis_req", {31'b0, dmem.req}, 32'h0);
    chk("mis_rw", {31'b0, RegWrite_out}, 32'h0);
    @(negedge clk);
    chk("mis_pulse", {31'b0, misalign_out}, 32'h0);
    @(posedge clk); #1;
`else
    MemRead = 1; MemtoReg = 1; RegWrite = 1;
    f3 = 3'b010; alu = 32'h102; Rd = 5'd9;
    do_access(0, 32'hCAFEF00D);
    chk("lwu_addr", cap_addr, 32'h100);
    chk("lwu_data", ReadData_out, 32'hCAFEF00D);
`endif

    // reset while a request is outstanding
    MemRead = 1; RegWrite = 1; f3 = 3'b010;
    alu = 32'h300; pc = 32'h40; Rd = 5'd2;
    @(negedge clk);
    @(posedge clk); #1;
    chk("mid_req", {31'b0, dmem.req}, 32'h1);
    #1 reset = 0;
    #1;
    chk("mr_req", {31'b0, dmem.req}, 32'h0);
    chk("mr_we", {31'b0, dmem.we}, 32'h0);
    chk("mr_rw", {31'b0, RegWrite_out}, 32'h0);
    chk("mr_pc", PC_out, 32'h0);
    chk("mr_alu", ALUresult_out, 32'h0);
    chk("mr_rdata", ReadData_out, 32'h0);
    chk("mr_rd", {27'b0, Rd_out}, 32'h0);
    nop();
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("mr_idle_stall", {31'b0, stall_out}, 32'h0);
    chk("mr_idle_req", {31'b0, dmem.req}, 32'h0);
    @(posedge clk); #1;
    MemRead = 1; RegWrite = 1; f3 = 3'b010;
    alu = 32'h10; Rd = 5'd6;
    do_access(0, 32'h5A5A5A5A);
    chk("rec_stall", nstall, 2);
    chk("rec_data", ReadData_out, 32'h5A5A5A5A);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
